pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised elastic pipeline register: DEPTH stages of WIDTH-bit data, each with a valid bit.
//  Valid/ready handshake at both ends; bubbles collapse under backpressure.
//  Synchronous flush plus an occupancy count.
//  Replaces hand-instantiated fixed 32-bit flop banks between datapath stages (PC, IF/ID, ID/EX, ...).
// PARAMETERS
//  WIDTH    32  data width in bits (>=1)
//  DEPTH    1   number of register stages (>=1)
//  RST_VAL  0   value loaded into every data stage on reset and on flush (WIDTH bits)
// PORTS
//  clk        in   1                  rising-edge clock
//  rst        in   1                  asynchronous, active-low reset
//  flush      in   1                  synchronous clear of all stages; priority over everything
//  in_valid   in   1                  upstream word present on in_data
//  in_ready   out  1                  chain accepts in_data this cycle
//  in_data    in   WIDTH              upstream data
//  out_valid  out  1                  valid bit of last stage (DEPTH-1)
//  out_ready  in   1                  downstream consumes out_data this cycle
//  out_data   out  WIDTH              data of last stage
//  occupancy  out  $clog2(DEPTH+1)    number of valid stages, 0..DEPTH
// BEHAVIOUR
//  Reset (rst=0, async, any time, mid-transfer included):
//   - all v[i]=0, all data[i]=RST_VAL, occupancy=0, out_valid=0, out_data=RST_VAL.
//   - in-flight words are lost.
//  Stage 0 is input side; stage DEPTH-1 drives out_*.
//  Move terms (combinational):
//   - mv[DEPTH-1] = !v[DEPTH-1] | out_ready
//   - mv[i] = !v[i] | mv[i+1] for i<DEPTH-1
//   - in_ready = mv[0] & !flush
//   - in_ready may depend combinationally on out_ready; permitted, documented path.
//  Per clock edge, flush=0:
//   - if mv[i]: v[i] <= src_valid; data[i] <= src_data only when src_valid=1, else data[i] holds.
//   - src = in_valid/in_data for i=0, v[i-1]/data[i-1] otherwise.
//   - if !mv[i]: v[i] and data[i] hold (stall).
//  Transfers:
//   - input transfer  = in_valid & in_ready.
//   - output transfer = out_valid & out_ready.
//   - out_data/out_valid stable while out_valid=1 & out_ready=0.
//  Latency: word accepted at edge k appears on out_* after edge k+DEPTH-1 when no stall.
//   - DEPTH=1: visible the cycle after acceptance.
//  Throughput: 1 word/cycle with out_ready held 1, any DEPTH.
//  Bubble collapse: an empty stage accepts from upstream even if a later stage is stalled.
//   - full chain holds DEPTH words; in_ready=0 only when all DEPTH stages valid and out_ready=0.
//  Occupancy:
//   - occupancy <= occupancy + in_xfer - out_xfer; equals popcount(v) at all times.
//   - never exceeds DEPTH nor wraps below 0.
//   - simultaneous in/out transfer leaves it unchanged.
//  Flush=1 at an edge:
//   - all v=0, all data=RST_VAL, occupancy=0.
//   - in_ready=0 during the flush cycle; nothing accepted.
//   - out transfer that cycle still counts as delivered downstream if out_ready=1.
//   - flush held N cycles keeps chain empty N cycles.
//  No other state; no FSM beyond per-stage valid bits.
// TESTING
//  1. Reset, WIDTH=32 DEPTH=3, out_ready=1:
//     send 0xDEADBEEF at edge 0 -> out_valid=1 and out_data=0xDEADBEEF after edge 2; occupancy 1,1,1,0.
//  2. DEPTH=3, out_ready=0, in_valid=1 with 1,2,3,4:
//     -> in_ready drops after 3 accepts, occupancy=3, out_data=1 held.
//     Then out_ready=1 -> outputs 1,2,3,4 in order, no loss or duplicate.
//  3. Bubble collapse, DEPTH=4: words A,_,B,_ with out_ready=0 -> stages compact, occupancy=2, in_ready=1.
//     Two more words accepted before in_ready=0.
//  4. Flush with chain full (DEPTH=3, RST_VAL=0x1234) -> next cycle out_valid=0, occupancy=0,
//     out_data=0x1234, in_ready=0 during flush cycle.
//  5. Assert rst=0 between clock edges mid-stream -> outputs go to reset values immediately (async).
//     Release -> first word after release has latency DEPTH.
//  6. DEPTH=1, random in_valid/out_ready for 10k cycles vs scoreboard -> order preserved, occupancy==popcount(v).
//     Full rate (1 word/cycle) whenever both held 1.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// ============================================================================
// Module   : pipe_reg_chain
// Brief    : Elastic DEPTH-stage valid/ready pipeline register with flush and
//            occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_reg_chain #(
    parameter int               WIDTH   = 32,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_move;
    logic [OCC_W-1:0] r_occ;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // A stage may load when it is empty or its contents move on; this lets
    // bubbles collapse even while the tail is stalled.
    assign w_move[DEPTH-1] = ~w_valid[DEPTH-1] | out_ready;

    generate
        for (genvar i = 0; i < DEPTH - 1; i++) begin : g_move
            assign w_move[i] = ~w_valid[i] | w_move[i+1];
        end
    endgenerate

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             w_src_valid;
            logic [WIDTH-1:0] w_src_data;
            logic             r_v;
            logic [WIDTH-1:0] r_d;

            if (i == 0) begin : g_head
                assign w_src_valid = in_valid;
                assign w_src_data  = in_data;
            end else begin : g_body
                assign w_src_valid = w_valid[i-1];
                assign w_src_data  = w_data[i-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_v <= 1'b0;
                    r_d <= RST_VAL;
                end else if (flush) begin
                    r_v <= 1'b0;
                    r_d <= RST_VAL;
                end else if (w_move[i]) begin
                    r_v <= w_src_valid;
                    if (w_src_valid) begin
                        r_d <= w_src_data;
                    end
                end
            end

            assign w_valid[i] = r_v;
            assign w_data[i]  = r_d;
        end
    endgenerate

    assign in_ready   = w_move[0] & ~flush;
    assign out_valid  = w_valid[DEPTH-1];
    assign out_data   = w_data[DEPTH-1];
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    assign occupancy = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
// ============================================================================
// Module   : tb_pipe_reg_chain
// Brief    : Self-checking bench for pipe_reg_chain at DEPTH 3, 4 and 1.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_reg_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_data;

    logic        ir3, ov3, ir4, ov4, ir1, ov1;
    logic [31:0] od3, od4, od1;
    logic [1:0]  oc3;
    logic [2:0]  oc4;
    logic [0:0]  oc1;

    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(32), .DEPTH(3), .RST_VAL(32'h0000_1234)) u_d3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
        .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3),
        .occupancy(oc3));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(4), .RST_VAL(32'h0)) u_d4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
        .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .occupancy(oc4));
    pipe_reg_chain #(.WIDTH(32), .DEPTH(1), .RST_VAL(32'h0)) u_d1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(oc1));

    // Reference model: slot list where each word steps forward when the
    // downstream end drains or any slot beyond it is empty.
    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][31:0] d;
    } mst_t;

    mst_t ms [3];

    function automatic int dep(int k);
        return (k == 0) ? 3 : ((k == 1) ? 4 : 1);
    endfunction

    function automatic logic [31:0] rv(int k);
        return (k == 0) ? 32'h0000_1234 : 32'h0;
    endfunction

    function automatic logic full_of(mst_t s, int d);
        logic f = 1'b1;
        for (int p = 0; p < d; p++) if (!s.v[p]) f = 1'b0;
        return f;
    endfunction

    function automatic int occ_of(mst_t s, int d);
        int n = 0;
        for (int p = 0; p < d; p++) if (s.v[p]) n++;
        return n;
    endfunction

    function automatic mst_t reset_state(int k);
        mst_t n;
        n.v = '0;
        for (int p = 0; p < 4; p++) n.d[p] = rv(k);
        return n;
    endfunction

    function automatic mst_t model_next(mst_t s, int d, logic [31:0] rstv, logic iv,
                                        logic [31:0] id, logic ordy, logic fl);
        mst_t n;
        logic empty_after;
        n   = s;
        n.v = '0;
        if (fl) begin
            for (int p = 0; p < 4; p++) n.d[p] = rstv;
            return n;
        end
        for (int p = d - 1; p >= 0; p--) begin
            if (s.v[p]) begin
                empty_after = 1'b0;
                for (int q = p + 1; q < d; q++) if (!s.v[q]) empty_after = 1'b1;
                if (p == d - 1) begin
                    if (!ordy) n.v[p] = 1'b1;
                end else if (ordy || empty_after) begin
                    n.v[p+1] = 1'b1;
                    n.d[p+1] = s.d[p];
                end else begin
                    n.v[p] = 1'b1;
                end
            end
        end
        if (iv && (ordy || !full_of(s, d))) begin
            n.v[0] = 1'b1;
            n.d[0] = id;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) ms[k] <= reset_state(k);
        end else begin
            for (int k = 0; k < 3; k++)
                ms[k] <= model_next(ms[k], dep(k), rv(k), in_valid, in_data, out_ready, flush);
        end
    end

    logic [2:0]  a_ir, a_ov;
    logic [31:0] a_od [3];
    int          a_oc [3];
    always_comb begin
        a_ir    = {ir1, ir4, ir3};
        a_ov    = {ov1, ov4, ov3};
        a_od[0] = od3;
        a_od[1] = od4;
        a_od[2] = od1;
        a_oc[0] = int'(oc3);
        a_oc[1] = int'(oc4);
        a_oc[2] = int'(oc1);
    end

    logic        e_ir, e_ov;
    logic [31:0] e_od;
    int          e_oc;
    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                e_ov = ms[k].v[dep(k)-1];
                e_od = ms[k].d[dep(k)-1];
                e_oc = occ_of(ms[k], dep(k));
                e_ir = !flush && (out_ready || !full_of(ms[k], dep(k)));
                checks++;
                if (a_ov[k] !== e_ov) begin errors++;
                    $display("FAIL model_out_valid d=%0d t=%0t got=%b exp=%b", dep(k), $time, a_ov[k], e_ov); end
                checks++;
                if (a_od[k] !== e_od) begin errors++;
                    $display("FAIL model_out_data d=%0d t=%0t got=%h exp=%h", dep(k), $time, a_od[k], e_od); end
                checks++;
                if (a_oc[k] !== e_oc) begin errors++;
                    $display("FAIL model_occupancy d=%0d t=%0t got=%0d exp=%0d", dep(k), $time, a_oc[k], e_oc); end
                checks++;
                if (a_ir[k] !== e_ir) begin errors++;
                    $display("FAIL model_in_ready d=%0d t=%0t got=%b exp=%b", dep(k), $time, a_ir[k], e_ir); end
            end
        end
    end

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #2;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov3); end
        checks++; if (od3 !== 32'h1234) begin errors++; $display("FAIL reset_out_data got=%h exp=00001234", od3); end
        checks++; if (oc3 !== 2'd0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", oc3); end
        checks++; if (od4 !== 32'h0) begin errors++; $display("FAIL reset_out_data_d4 got=%h exp=0", od4); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_latency();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (oc3 !== 2'd1 || ov3 !== 1'b0) begin errors++;
            $display("FAIL lat_edge0 got occ=%0d ov=%b exp occ=1 ov=0", oc3, ov3); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (oc3 !== 2'd1 || ov3 !== 1'b0) begin errors++;
            $display("FAIL lat_edge1 got occ=%0d ov=%b exp occ=1 ov=0", oc3, ov3); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (oc3 !== 2'd1 || ov3 !== 1'b1 || od3 !== 32'hDEAD_BEEF) begin errors++;
            $display("FAIL lat_edge2 got occ=%0d ov=%b od=%h exp occ=1 ov=1 od=deadbeef", oc3, ov3, od3); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (oc3 !== 2'd0 || ov3 !== 1'b0) begin errors++;
            $display("FAIL lat_edge3 got occ=%0d ov=%b exp occ=0 ov=0", oc3, ov3); end
    endtask

    task automatic test_backpressure();
        int n = 1;
        int exp_w = 1;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 32'(n), 1'b0, 1'b0);
            if (ir3) n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL bp_accepts got=%0d exp=3", n - 1); end
        checks++; if (ir3 !== 1'b0 || oc3 !== 2'd3) begin errors++;
            $display("FAIL bp_full got ir=%b occ=%0d exp ir=0 occ=3", ir3, oc3); end
        checks++; if (ov3 !== 1'b1 || od3 !== 32'd1) begin errors++;
            $display("FAIL bp_hold got ov=%b od=%h exp ov=1 od=1", ov3, od3); end
        for (int c = 0; c < 12; c++) begin
            drive(n <= 4, 32'(n), 1'b1, 1'b0);
            if (ov3) begin
                checks++;
                if (od3 !== 32'(exp_w)) begin errors++;
                    $display("FAIL bp_order got=%h exp=%h", od3, 32'(exp_w)); end
                exp_w++;
            end
            if (ir3 && n <= 4) n++;
        end
        checks++; if (exp_w !== 5) begin errors++; $display("FAIL bp_drained got=%0d exp=4", exp_w - 1); end
    endtask

    task automatic test_bubble();
        int acc = 0;
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (oc4 !== 3'd2 || ir4 !== 1'b1) begin errors++;
            $display("FAIL bubble_compact got occ=%0d ir=%b exp occ=2 ir=1", oc4, ir4); end
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'hC0 + 32'(c), 1'b0, 1'b0);
            if (ir4) acc++;
        end
        checks++; if (acc !== 2 || oc4 !== 3'd4 || ir4 !== 1'b0) begin errors++;
            $display("FAIL bubble_fill got acc=%0d occ=%0d ir=%b exp acc=2 occ=4 ir=0", acc, oc4, ir4); end
        checks++; if (od4 !== 32'hA) begin errors++; $display("FAIL bubble_head got=%h exp=a", od4); end
    endtask

    task automatic test_flush();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (4) drive(1'b1, $urandom, 1'b0, 1'b0);
        checks++; if (oc3 !== 2'd3) begin errors++; $display("FAIL flush_prefill got=%0d exp=3", oc3); end
        drive(1'b1, 32'h9, 1'b1, 1'b1);
        checks++; if (ir3 !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%b exp=0", ir3); end
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h9, 1'b1, c < 2);
            checks++; if (ov3 !== 1'b0 || oc3 !== 2'd0 || od3 !== 32'h1234) begin errors++;
                $display("FAIL flush_empty c=%0d got ov=%b occ=%0d od=%h exp ov=0 occ=0 od=1234", c, ov3, oc3, od3); end
        end
    endtask

    task automatic test_async_reset();
        repeat (3) drive(1'b1, $urandom, 1'b1, 1'b0);
        repeat (3) drive(1'b1, $urandom, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (ov3 !== 1'b0 || oc3 !== 2'd0 || od3 !== 32'h1234) begin errors++;
            $display("FAIL async_rst_d3 got ov=%b occ=%0d od=%h exp ov=0 occ=0 od=1234", ov3, oc3, od3); end
        checks++; if (ov4 !== 1'b0 || oc4 !== 3'd0 || ov1 !== 1'b0 || oc1 !== 1'b0) begin errors++;
            $display("FAIL async_rst_other got ov4=%b oc4=%0d ov1=%b oc1=%0d exp all 0", ov4, oc4, ov1, oc1); end
        #1 rst = 1'b1;
        drive(1'b1, 32'hCAFE, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (ov3 !== (c == 2)) begin errors++;
                $display("FAIL async_lat_d3 edge=%0d got=%b exp=%b", c, ov3, c == 2); end
            checks++; if (ov4 !== (c == 3)) begin errors++;
                $display("FAIL async_lat_d4 edge=%0d got=%b exp=%b", c, ov4, c == 3); end
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_w;
        logic        iv, ordy, fl;
        logic [31:0] d;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int c = 0; c < 10000; c++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 63) == 0);
            d    = $urandom;
            drive(iv, d, ordy, fl);
            checks++; if (int'(oc1) !== q.size()) begin errors++;
                $display("FAIL rand_occupancy c=%0d got=%0d exp=%0d", c, oc1, q.size()); end
            checks++; if (ov1 !== (q.size() != 0)) begin errors++;
                $display("FAIL rand_out_valid c=%0d got=%b exp=%b", c, ov1, q.size() != 0); end
            if (iv && ordy && !fl) begin
                checks++; if (ir1 !== 1'b1) begin errors++;
                    $display("FAIL rand_full_rate c=%0d got=%b exp=1", c, ir1); end
            end
            if (ov1 && ordy && q.size() != 0) begin
                exp_w = q.pop_front();
                checks++; if (od1 !== exp_w) begin errors++;
                    $display("FAIL rand_order c=%0d got=%h exp=%h", c, od1, exp_w); end
            end
            if (fl) q.delete();
            else if (iv && ir1) q.push_back(d);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_bubble();
        test_flush();
        test_async_reset();
        test_random();
        @(negedge clk);
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
